// File: rtl/aes_ctr_pkg.sv
// Shared constants and FSM state encoding for the AES-128 CTR transmit/receive pair.
package aes_ctr_pkg;

  localparam int unsigned KEY_W           = 128;
  localparam int unsigned BLK_W           = 128;
  localparam int unsigned NONCE_W         = 64;
  localparam int unsigned CTR_W           = 64;
  localparam int unsigned AES_LATENCY_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctr_state_e;

endpackage

// File: rtl/aes_128.sv
// Pipelined AES-128 encryption core: two register stages per round, 20 cycles state->out.
// Free-running with no reset or stall; round keys travel alongside the data.
module aes_128 (
  input  logic         clk,
  input  logic [127:0] key,
  input  logic [127:0] state,
  output logic [127:0] out
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [79:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) lives at index 4*c+r, MSB-first.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] s_in [10];
  logic [127:0] k_in [10];
  logic [127:0] sa_q [10];
  logic [127:0] ka_q [10];
  logic [127:0] sb_q [10];
  logic [127:0] kb_q [9];

  always_comb begin
    s_in[0] = state ^ key;
    k_in[0] = key;
    for (int unsigned r = 1; r < 10; r++) begin
      s_in[r] = sb_q[r - 1];
      k_in[r] = kb_q[r - 1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < 10; r++) begin
      sa_q[r] <= sub_shift(s_in[r]);
      ka_q[r] <= key_step(k_in[r], RCON[79 - 8 * r -: 8]);
      sb_q[r] <= ((r == 9) ? sa_q[r] : mix_columns(sa_q[r])) ^ ka_q[r];
    end
    for (int unsigned r = 0; r < 9; r++) begin
      kb_q[r] <= ka_q[r];
    end
  end

  assign out = sb_q[9];

endmodule

// File: rtl/ctr_delay_line.sv
// Free-running shift register with a per-stage valid bit; keeps ciphertext aligned
// with the keystream emerging from the AES pipeline.
module ctr_delay_line #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned WIDTH = 129
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i - 1];
        dat_q[i] <= dat_q[i - 1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/aes_ctr_rx_decrypt.sv
// Receive-side AES-128 CTR decryptor: regenerates {nonce, counter} keystream per accepted
// ciphertext block and emits plaintext in order, 1 block/cycle.
module aes_ctr_rx_decrypt
  import aes_ctr_pkg::*;
#(
  parameter int unsigned AES_LATENCY = AES_LATENCY_DEF,
  parameter int unsigned LEN_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W-1:0]   key,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   counter_init,
  input  logic [LEN_W-1:0]   num_blocks,
  input  logic               cipher_valid,
  output logic               cipher_ready,
  input  logic [BLK_W-1:0]   cipher_in,
  output logic               msg_valid,
  output logic [BLK_W-1:0]   msg_out,
  output logic               msg_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      DL_W    = BLK_W + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  ctr_state_e         state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   inflight_q, inflight_d;
  logic               done_q, done_d;
  logic               msg_valid_q, msg_last_q;
  logic [BLK_W-1:0]   msg_out_q;
  logic [BLK_W-1:0]   keystream;
  logic               accept;
  logic               dl_valid;
  logic [DL_W-1:0]    dl_data;

  assign cipher_ready = (state_q == ST_RUN);
  assign accept       = cipher_ready & cipher_valid;
  assign busy         = (state_q != ST_IDLE);

  aes_128 keystream_gen (
    .clk   (clk),
    .key   (key),
    .state ({nonce_q, ctr_q}),
    .out   (keystream)
  );

  ctr_delay_line #(
    .DEPTH (AES_LATENCY),
    .WIDTH (DL_W)
  ) cipher_dly (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (accept),
    .data_i  ({remaining_q == LEN_ONE, cipher_in}),
    .valid_o (dl_valid),
    .data_o  (dl_data)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !msg_valid_q) begin
      inflight_d = inflight_q + LEN_ONE;
    end else if (!accept && msg_valid_q) begin
      inflight_d = inflight_q - LEN_ONE;
    end
  end

  // DRAIN looks at next-cycle inflight so done lands exactly one cycle after msg_last.
  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nonce_d     = nonce;
          ctr_d       = counter_init;
          remaining_d = num_blocks;
          if (num_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          ctr_d       = ctr_q + CTR_W'(1);
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nonce_q     <= '0;
      ctr_q       <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      done_q      <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_last_q  <= 1'b0;
      msg_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      msg_valid_q <= dl_valid;
      msg_last_q  <= dl_valid & dl_data[DL_W-1];
      if (dl_valid) begin
        msg_out_q <= keystream ^ dl_data[BLK_W-1:0];
      end
    end
  end

  assign msg_valid = msg_valid_q;
  assign msg_last  = msg_last_q;
  assign msg_out   = msg_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_ctr_rx_decrypt.sv
// Self-checking bench for aes_ctr_rx_decrypt: NIST CTR vectors, an independent AES
// reference model, and a scoreboard that checks data, last flag and latency.
module tb_aes_ctr_rx_decrypt;

  localparam int unsigned LAT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         start;
  logic [63:0]  nonce;
  logic [63:0]  counter_init;
  logic [15:0]  num_blocks;
  logic         cipher_valid;
  logic         cipher_ready;
  logic [127:0] cipher_in;
  logic         msg_valid;
  logic [127:0] msg_out;
  logic         msg_last;
  logic         busy;
  logic         done;

  aes_ctr_rx_decrypt #(.AES_LATENCY(LAT), .LEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .start        (start),
    .nonce        (nonce),
    .counter_init (counter_init),
    .num_blocks   (num_blocks),
    .cipher_valid (cipher_valid),
    .cipher_ready (cipher_ready),
    .cipher_in    (cipher_in),
    .msg_valid    (msg_valid),
    .msg_out      (msg_out),
    .msg_last     (msg_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
    int unsigned  cyc;
  } exp_t;

  typedef struct {
    logic [127:0] cipher;
    logic [127:0] plain;
  } vec_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  vec_t        nist [4];
  logic [7:0]  sbox_m [256];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned mv_seen = 0;
  int unsigned last_drive = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (msg_valid) begin
        n_checks++;
        $display("FAIL done_overlap: done and msg_valid both 1 at cycle %0d", cyc);
      end
    end
    if (msg_valid) begin
      mv_seen++;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_msg: msg_valid=1 msg_out=%h at cycle %0d, none required", msg_out, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("msg_out", msg_out, mon_e.data);
        check("msg_last", 128'(msg_last), 128'(mon_e.last));
        check("latency", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  // Reference AES: S-box derived from GF(2^8) inverses, byte-array rounds.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   st [16];
    logic [7:0]   rk [16];
    logic [7:0]   tmp [16];
    logic [7:0]   t [4];
    logic [7:0]   rc, acc, cf;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = k[127 - 8 * i -: 8];
      st[i] = pt[127 - 8 * i -: 8] ^ rk[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_m[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[4 * c + r] = tmp[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) tmp[r] = st[4 * c + r];
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
              case ((j + 4 - r) % 4)
                0:       cf = 8'h02;
                1:       cf = 8'h03;
                default: cf = 8'h01;
              endcase
              acc ^= gm(cf, tmp[j]);
            end
            st[4 * c + r] = acc;
          end
        end
      end
      t[0] = sbox_m[rk[13]] ^ rc;
      t[1] = sbox_m[rk[14]];
      t[2] = sbox_m[rk[15]];
      t[3] = sbox_m[rk[12]];
      for (int i = 0; i < 4; i++) rk[i] ^= t[i];
      for (int i = 4; i < 16; i++) rk[i] ^= rk[i - 4];
      rc = gm(rc, 8'h02);
      for (int i = 0; i < 16; i++) st[i] ^= rk[i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [63:0] n, input logic [63:0] c, input logic [15:0] nb);
    nonce        = n;
    counter_init = c;
    num_blocks   = nb;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    nonce        = ~n;
    counter_init = ~c;
    num_blocks   = 16'h00ff;
  endtask

  task automatic send(input logic [127:0] c, input logic [127:0] p, input logic last);
    exp_t e;
    cipher_valid = 1'b1;
    cipher_in    = c;
    check("cipher_ready_run", 128'(cipher_ready), 128'd1);
    e.data = p;
    e.last = last;
    e.cyc  = cyc + LAT + 1;
    sb_q.push_back(e);
    last_drive = cyc;
    tick();
    cipher_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned exp_done, input string tag);
    int unsigned d0;
    int unsigned k;
    d0 = done_cnt;
    k  = 0;
    while ((busy || sb_q.size() != 0 || done_cnt == d0) && k < 80) begin
      tick();
      k++;
    end
    check({tag, "_done_count"}, 128'(done_cnt - d0), 128'd1);
    check({tag, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
    check({tag, "_all_emitted"}, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [127:0] ct, ct2;
    logic [63:0]  n1, c1;
    int unsigned  m0, s;

    nist[0] = '{128'h874d6191b620e3261bef6864990db6ce, 128'h6bc1bee22e409f96e93d7e117393172a};
    nist[1] = '{128'h9806f66b7970fdff8617187bb9fffdff, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    nist[2] = '{128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    nist[3] = '{128'h1e031dda2fbe03d1792170a0f3009cee, 128'hf69f2445df4f9b17ad2b417be66c3710};

    rst_n = 1'b0; key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b0; nonce = '0; counter_init = '0; num_blocks = '0;
    cipher_valid = 1'b0; cipher_in = '0;
    build_sbox();
    repeat (3) tick();
    check("rst_cipher_ready", 128'(cipher_ready), 128'd0);
    check("rst_msg_valid", 128'(msg_valid), 128'd0);
    check("rst_msg_last", 128'(msg_last), 128'd0);
    check("rst_msg_out", msg_out, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    tick();

    // NIST single block
    start_msg(64'hf0f1f2f3f4f5f6f7, 64'hf8f9fafbfcfdfeff, 16'd1);
    check("t1_busy", 128'(busy), 128'd1);
    send(nist[0].cipher, nist[0].plain, 1'b1);
    wait_idle(last_drive + LAT + 2, "t1");

    // NIST four blocks back-to-back, table-driven
    start_msg(64'hf0f1f2f3f4f5f6f7, 64'hf8f9fafbfcfdfeff, 16'd4);
    for (int i = 0; i < 4; i++) send(nist[i].cipher, nist[i].plain, i == 3);
    check("t2_ready_after_last", 128'(cipher_ready), 128'd0);
    wait_idle(last_drive + LAT + 2, "t2");

    // 64-bit counter wrap
    n1 = 64'h0123456789abcdef;
    ct = rand128(); ct2 = rand128();
    start_msg(n1, 64'hffffffffffffffff, 16'd2);
    send(ct, ct ^ aes_ref(key, {n1, 64'hffffffffffffffff}), 1'b0);
    send(ct2, ct2 ^ aes_ref(key, {n1, 64'h0}), 1'b1);
    wait_idle(last_drive + LAT + 2, "t3");

    // Gaps, valid held in IDLE/DRAIN, start ignored in RUN
    n1 = 64'h0011223344556677;
    c1 = 64'h00000000fffffffe;
    cipher_valid = 1'b1; cipher_in = rand128();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_ready_idle", 128'(cipher_ready), 128'd0);
    end
    cipher_valid = 1'b0;
    start_msg(n1, c1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i == 1) begin
        nonce = 64'hdeadbeefcafef00d; counter_init = '0; num_blocks = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      ct = rand128();
      send(ct, ct ^ aes_ref(key, {n1, c1 + 64'(i)}), i == 2);
    end
    cipher_valid = 1'b1; cipher_in = rand128();
    check("t4_ready_drain", 128'(cipher_ready), 128'd0);
    wait_idle(last_drive + LAT + 2, "t4");
    cipher_valid = 1'b0;

    // Zero-length message
    s = done_cnt;
    start_msg(64'h1, 64'h2, 16'd0);
    check("t5_done_pulse", 128'(done), 128'd1);
    check("t5_ready", 128'(cipher_ready), 128'd0);
    check("t5_busy", 128'(busy), 128'd0);
    tick();
    check("t5_done_once", 128'(done), 128'd0);
    repeat (LAT + 3) tick();
    check("t5_ready_stays_low", 128'(cipher_ready), 128'd0);
    check("t5_done_count", 128'(done_cnt - s), 128'd1);

    // Reset with blocks in flight, then recover
    key = 128'h000102030405060708090a0b0c0d0e0f;
    n1  = 64'h0102030405060708;
    start_msg(n1, 64'h10, 16'd5);
    for (int i = 0; i < 5; i++) begin
      ct = rand128();
      send(ct, ct ^ aes_ref(key, {n1, 64'h10 + 64'(i)}), i == 4);
    end
    repeat (3) tick();
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("t6_rst_msg_valid", 128'(msg_valid), 128'd0);
    check("t6_rst_msg_out", msg_out, 128'd0);
    check("t6_rst_busy", 128'(busy), 128'd0);
    check("t6_rst_ready", 128'(cipher_ready), 128'd0);
    check("t6_rst_done", 128'(done), 128'd0);
    tick();
    rst_n = 1'b1;
    m0 = mv_seen;
    repeat (LAT + 2) tick();
    check("t6_quiet_after_reset", 128'(mv_seen - m0), 128'd0);
    start_msg(n1, 64'h100, 16'd2);
    for (int i = 0; i < 2; i++) begin
      ct = rand128();
      send(ct, ct ^ aes_ref(key, {n1, 64'h100 + 64'(i)}), i == 1);
    end
    wait_idle(last_drive + LAT + 2, "t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
